// File: rtl/flash.sv
// Single-shot SPI flash sequencer: write-enable, page program, busy poll, read-back.
// Define FLASH_ERASE_EN to prefix the program with a write-enable + sector erase + busy poll.
module flash #(
    parameter logic [23:0] ADDR     = 24'h000000,
    parameter logic [7:0]  WR_DATA  = 8'hA5,
    parameter int unsigned CLK_DIV  = 2,
    parameter int unsigned CS_GAP   = 4,
    parameter int unsigned POLL_MAX = 65535
) (
    input  logic       sclk,
    input  logic       srst_n,
    input  logic       en,
    input  logic       spi_di,
    output logic       spi_clk,
    output logic       spi_do,
    output logic       spi_cs,
    output logic [7:0] datareadout
);

    typedef enum logic [2:0] {
        S_IDLE, S_WREN, S_PROG, S_POLL, S_READ, S_EWREN, S_ERASE, S_EPOLL
    } state_t;

    typedef enum logic [2:0] {
        P_IDLE, P_LEAD, P_HIGH, P_LOW, P_TRAIL, P_GAP
    } phase_t;

    localparam logic [15:0] DIV_M1   = 16'(CLK_DIV - 1);
    localparam logic [15:0] GAP_M1   = (CS_GAP > 1) ? 16'(CS_GAP - 1) : 16'd0;
    localparam logic [31:0] POLL_LIM = 32'(POLL_MAX);

`ifdef FLASH_ERASE_EN
    localparam state_t FIRST = S_EWREN;
`else
    localparam state_t FIRST = S_WREN;
`endif

    // Outgoing bits are left-aligned; trailing zeros give a quiet MOSI during input-only bits.
    function automatic logic [39:0] frame_tx(input state_t s);
        case (s)
            S_WREN, S_EWREN: frame_tx = {8'h06, 32'h0};
            S_PROG:          frame_tx = {8'h02, ADDR, WR_DATA};
            S_POLL, S_EPOLL: frame_tx = {8'h05, 32'h0};
            S_READ:          frame_tx = {8'h03, ADDR, 8'h00};
            S_ERASE:         frame_tx = {8'h20, ADDR[23:12], 12'h000, 8'h00};
            default:         frame_tx = '0;
        endcase
    endfunction

    function automatic logic [5:0] frame_bits(input state_t s);
        case (s)
            S_WREN, S_EWREN: frame_bits = 6'd8;
            S_PROG, S_READ:  frame_bits = 6'd40;
            S_POLL, S_EPOLL: frame_bits = 6'd16;
            S_ERASE:         frame_bits = 6'd32;
            default:         frame_bits = 6'd0;
        endcase
    endfunction

    state_t      state, state_n;
    phase_t      phase, phase_n;
    logic [15:0] cnt, cnt_n;
    logic [5:0]  bit_cnt, bit_n;
    logic [5:0]  nbits, nbits_n;
    logic [38:0] tx_sr, tx_n;
    logic [7:0]  rx_sr, rx_n;
    logic [31:0] poll_cnt, poll_n, poll_next;
    logic [39:0] tx_word;
    logic        en_q;
    logic        dr_load, dr_load_n;
    logic        clk_n, cs_n, do_n;
    logic        launch;
    logic        start;

    assign start = en & ~en_q;

    always_comb begin
        state_n   = state;
        phase_n   = phase;
        cnt_n     = cnt;
        bit_n     = bit_cnt;
        nbits_n   = nbits;
        tx_n      = tx_sr;
        rx_n      = rx_sr;
        poll_n    = poll_cnt;
        poll_next = poll_cnt + 32'd1;
        clk_n     = spi_clk;
        cs_n      = spi_cs;
        do_n      = spi_do;
        dr_load_n = 1'b0;
        launch    = 1'b0;
        tx_word   = '0;

        case (phase)
            P_IDLE: begin
                if (start) begin
                    state_n = FIRST;
                    launch  = 1'b1;
                end
            end
            P_LEAD, P_LOW: begin
                if (cnt == DIV_M1) begin
                    cnt_n   = '0;
                    clk_n   = 1'b1;
                    rx_n    = {rx_sr[6:0], spi_di};
                    bit_n   = bit_cnt + 6'd1;
                    phase_n = P_HIGH;
                    if (state == S_READ && bit_n == nbits) dr_load_n = 1'b1;
                end else begin
                    cnt_n = cnt + 16'd1;
                end
            end
            P_HIGH: begin
                if (cnt == DIV_M1) begin
                    cnt_n = '0;
                    clk_n = 1'b0;
                    if (bit_cnt == nbits) begin
                        phase_n = P_TRAIL;
                    end else begin
                        phase_n = P_LOW;
                        do_n    = tx_sr[38];
                        tx_n    = {tx_sr[37:0], 1'b0};
                    end
                end else begin
                    cnt_n = cnt + 16'd1;
                end
            end
            P_TRAIL: begin
                if (cnt == DIV_M1) begin
                    cnt_n   = '0;
                    cs_n    = 1'b1;
                    do_n    = 1'b0;
                    phase_n = P_GAP;
                end else begin
                    cnt_n = cnt + 16'd1;
                end
            end
            P_GAP: begin
                // The next frame is decided and launched on the same edge the gap expires.
                if (cnt == GAP_M1) begin
                    cnt_n = '0;
                    case (state)
                        S_WREN: state_n = S_PROG;
                        S_PROG: state_n = S_POLL;
                        S_POLL, S_EPOLL: begin
                            if (!rx_sr[0]) begin
                                poll_n = '0;
                                if (state == S_POLL) state_n = S_READ;
                                else                 state_n = S_WREN;
                            end else if (poll_next >= POLL_LIM) begin
                                poll_n  = '0;
                                state_n = S_IDLE;
                            end else begin
                                poll_n = poll_next;
                            end
                        end
`ifdef FLASH_ERASE_EN
                        S_EWREN: state_n = S_ERASE;
                        S_ERASE: state_n = S_EPOLL;
`endif
                        default: state_n = S_IDLE;
                    endcase
                    if (state_n == S_IDLE) phase_n = P_IDLE;
                    else                   launch  = 1'b1;
                end else begin
                    cnt_n = cnt + 16'd1;
                end
            end
            default: begin
                state_n = S_IDLE;
                phase_n = P_IDLE;
            end
        endcase

        if (launch) begin
            tx_word = frame_tx(state_n);
            nbits_n = frame_bits(state_n);
            phase_n = P_LEAD;
            cnt_n   = '0;
            bit_n   = '0;
            cs_n    = 1'b0;
            do_n    = tx_word[39];
            tx_n    = tx_word[38:0];
        end
    end

    always_ff @(posedge sclk) begin
        if (!srst_n) begin
            state       <= S_IDLE;
            phase       <= P_IDLE;
            cnt         <= '0;
            bit_cnt     <= '0;
            nbits       <= '0;
            tx_sr       <= '0;
            rx_sr       <= '0;
            poll_cnt    <= '0;
            en_q        <= 1'b0;
            dr_load     <= 1'b0;
            spi_clk     <= 1'b0;
            spi_cs      <= 1'b1;
            spi_do      <= 1'b0;
            datareadout <= '0;
        end else begin
            state    <= state_n;
            phase    <= phase_n;
            cnt      <= cnt_n;
            bit_cnt  <= bit_n;
            nbits    <= nbits_n;
            tx_sr    <= tx_n;
            rx_sr    <= rx_n;
            poll_cnt <= poll_n;
            en_q     <= en;
            dr_load  <= dr_load_n;
            spi_clk  <= clk_n;
            spi_cs   <= cs_n;
            spi_do   <= do_n;
            if (dr_load) datareadout <= rx_sr;
        end
    end

endmodule

// File: tb/tb_flash.sv
// Bench for flash: behavioural SPI flash slave, frame scoreboard and protocol timing monitor.
// Expected frames follow the FLASH_ERASE_EN setting of the build.
module tb_flash;

    localparam logic [23:0] T_ADDR = 24'h3C5A81;
    localparam logic [7:0]  T_WR   = 8'hB7;
    localparam int          T_DIV  = 2;
    localparam int          T_GAP  = 4;
    localparam int          T_PM   = 4;

    logic       sclk = 1'b0;
    logic       srst_n;
    logic       en;
    logic       spi_di;
    logic       spi_clk;
    logic       spi_do;
    logic       spi_cs;
    logic [7:0] datareadout;

    flash #(
        .ADDR(T_ADDR), .WR_DATA(T_WR), .CLK_DIV(T_DIV), .CS_GAP(T_GAP), .POLL_MAX(T_PM)
    ) dut (
        .sclk(sclk), .srst_n(srst_n), .en(en), .spi_di(spi_di),
        .spi_clk(spi_clk), .spi_do(spi_do), .spi_cs(spi_cs), .datareadout(datareadout)
    );

    always #5 sclk = ~sclk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- flash slave model ----------------
    typedef struct { int n; logic [63:0] v; } frame_t;
    frame_t      frames[$];
    frame_t      exp_q[$];
    logic [63:0] f_val     = '0;
    int          f_bits    = 0;
    logic [7:0]  f_cmd     = '0;
    logic [7:0]  f_status  = '0;
    logic [7:0]  mem_byte  = '0;
    int          busy_left = 0;
    int          busy_set  = 0;
    bit          stuck     = 0;
    logic [7:0]  exp_dr    = '0;

    function automatic logic miso_bit(input int i);
        logic [31:0] r;
        r = $urandom;
        if (stuck) return 1'b1;
        if (f_cmd == 8'h05 && i >= 8 && i < 16) return f_status[15 - i];
        if (f_cmd == 8'h03 && i >= 32 && i < 40) return mem_byte[39 - i];
        return r[0];
    endfunction

    always @(negedge spi_cs) begin
        f_bits      = 0;
        f_val       = '0;
        f_status    = 8'($urandom);
        f_status[0] = (busy_left > 0);
        spi_di      = miso_bit(0);
    end

    always @(posedge spi_clk) begin
        if (spi_cs === 1'b0) begin
            f_val = {f_val[62:0], spi_do};
            f_bits++;
            if (f_bits == 8) f_cmd = f_val[7:0];
        end
    end

    always @(negedge spi_clk) begin
        if (spi_cs === 1'b0) spi_di = miso_bit(f_bits);
    end

    always @(posedge spi_cs) begin
        frame_t fr;
        fr.n = f_bits;
        fr.v = f_val;
        frames.push_back(fr);
        if (f_bits == 40 && f_val[39:32] == 8'h02) begin
            mem_byte  = mem_byte & f_val[7:0];
            busy_left = busy_set;
        end
        if (f_bits == 32 && f_val[31:24] == 8'h20) begin
            mem_byte  = 8'hFF;
            busy_left = busy_set;
        end
        if (f_bits == 16 && f_val[15:8] == 8'h05 && busy_left > 0) busy_left--;
    end

    // ---------------- protocol timing monitor ----------------
    int   cyc = 0, run = 0, gap = 0, last_rise = 0;
    bit   gap_valid = 0;
    logic p_rst = 1'b0, p_cs = 1'b1, p_clk = 1'b0, p_do = 1'b0;
    logic [7:0] p_dr = '0;
    int   viol_phase = 0, viol_gap = 0, viol_do_idle = 0, viol_clk_idle = 0, viol_do_edge = 0;

    always @(negedge sclk) begin
        cyc++;
        if (!srst_n) begin
            gap_valid = 0;
        end else begin
            if (spi_cs === 1'b1 && spi_do !== 1'b0)  viol_do_idle++;
            if (spi_cs === 1'b1 && spi_clk !== 1'b0) viol_clk_idle++;
            if (p_rst) begin
                if (spi_do !== p_do && !((p_clk === 1'b1 && spi_clk === 1'b0) || spi_cs !== p_cs))
                    viol_do_edge++;
                if (p_cs === 1'b1 && spi_cs === 1'b0) begin
                    if (gap_valid && gap < T_GAP) viol_gap++;
                    run = 1;
                end else if (p_cs === 1'b0 && spi_cs === 1'b1) begin
                    if (run != T_DIV) viol_phase++;
                    gap       = 1;
                    gap_valid = 1;
                end else if (spi_cs === 1'b0) begin
                    if (spi_clk !== p_clk) begin
                        if (run != T_DIV) viol_phase++;
                        run = 1;
                        if (spi_clk === 1'b1) last_rise = cyc;
                    end else begin
                        run++;
                    end
                end else begin
                    gap++;
                end
                if (datareadout !== p_dr) check("dr_latency", 64'(cyc - last_rise), 64'd1);
            end
        end
        p_rst = srst_n;
        p_cs  = spi_cs;
        p_clk = spi_clk;
        p_do  = spi_do;
        p_dr  = datareadout;
    end

    // ---------------- stimulus and scoreboard ----------------
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge sclk);
            #2;
        end
    endtask

    task automatic push_exp(input int n, input logic [63:0] v);
        frame_t fr;
        fr.n = n;
        fr.v = v;
        exp_q.push_back(fr);
    endtask

    task automatic build_expected(input int b, input bit stk, input logic [7:0] old);
        int         polls;
        bit         ok;
        logic [7:0] base;
        polls = stk ? T_PM : ((b + 1 < T_PM) ? b + 1 : T_PM);
        ok    = !stk && (b + 1 <= T_PM);
        base  = old;
        exp_q.delete();
`ifdef FLASH_ERASE_EN
        push_exp(8, 64'h06);
        push_exp(32, 64'({8'h20, T_ADDR[23:12], 12'h000}));
        repeat (polls) push_exp(16, 64'h0500);
        base = 8'hFF;
        if (ok) begin
`else
        begin
`endif
            push_exp(8, 64'h06);
            push_exp(40, 64'({8'h02, T_ADDR, T_WR}));
            repeat (polls) push_exp(16, 64'h0500);
            if (ok) begin
                push_exp(40, 64'({8'h03, T_ADDR, 8'h00}));
                exp_dr = base & T_WR;
            end
        end
    endtask

    task automatic setup_model(input int b, input bit stk, input logic [7:0] old);
        busy_set  = b;
        stuck     = stk;
        mem_byte  = old;
        busy_left = 0;
        build_expected(b, stk, old);
    endtask

    task automatic finish_seq();
        int budget = 8000;
        while (frames.size() < exp_q.size() && budget > 0) begin
            tick(1);
            budget--;
        end
        if (budget == 0) check("seq_timeout", 64'(frames.size()), 64'(exp_q.size()));
        tick(60);
        check("n_frames", 64'(frames.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < frames.size(); i++) begin
            check($sformatf("frm%0d_bits", i), 64'(frames[i].n), 64'(exp_q[i].n));
            check($sformatf("frm%0d_data", i), frames[i].v, exp_q[i].v);
        end
        check("datareadout", 64'(datareadout), 64'(exp_dr));
        check("cs_idle", 64'(spi_cs), 64'd1);
        check("clk_phase_len", 64'(viol_phase), 64'd0);
        check("cs_gap", 64'(viol_gap), 64'd0);
        check("do_when_cs_high", 64'(viol_do_idle), 64'd0);
        check("clk_when_cs_high", 64'(viol_clk_idle), 64'd0);
        check("do_change_edge", 64'(viol_do_edge), 64'd0);
        viol_phase = 0; viol_gap = 0; viol_do_idle = 0; viol_clk_idle = 0; viol_do_edge = 0;
    endtask

    task automatic run_seq(input int b, input bit stk, input logic [7:0] old, input bit dbl);
        int budget = 4000;
        setup_model(b, stk, old);
        frames.delete();
        en = 1'b1;
        tick($urandom_range(1, 3));
        en = 1'b0;
        if (dbl) begin
            while (frames.size() < 3 && budget > 0) begin
                tick(1);
                budget--;
            end
            en = 1'b1;
            tick(2);
            en = 1'b0;
        end
        finish_seq();
    endtask

    initial begin
        int budget;
        srst_n = 1'b0;
        en     = 1'b0;
        spi_di = 1'b0;
        tick(3);
        check("rst_cs", 64'(spi_cs), 64'd1);
        check("rst_clk", 64'(spi_clk), 64'd0);
        check("rst_do", 64'(spi_do), 64'd0);
        check("rst_dout", 64'(datareadout), 64'd0);
        srst_n = 1'b1;
        frames.delete();
        tick(5);

        // Nominal: two busy polls then ready
        run_seq(2, 0, 8'hFF, 0);

        for (int i = 0; i < 10; i++)
            run_seq(int'($urandom_range(0, 5)), ($urandom_range(0, 5) == 0),
                    8'($urandom), bit'($urandom_range(0, 1)));

        // MISO stuck high: poll limit reached, no read
        run_seq(0, 1, 8'h00, 0);

        // Reset while the program frame is on the wire
        setup_model(1, 0, 8'h5A);
        frames.delete();
        en = 1'b1;
        tick(1);
        en = 1'b0;
        budget = 4000;
        while (!(spi_cs === 1'b0 && f_cmd == 8'h02 && f_bits == 20) && budget > 0) begin
            tick(1);
            budget--;
        end
        check("prog_bit20_reached", 64'(f_bits), 64'd20);
        srst_n = 1'b0;
        @(posedge sclk);
        #1;
        check("abort_cs", 64'(spi_cs), 64'd1);
        check("abort_clk", 64'(spi_clk), 64'd0);
        check("abort_do", 64'(spi_do), 64'd0);
        check("abort_dout", 64'(datareadout), 64'd0);
        @(posedge sclk);
        #2;
        srst_n = 1'b1;
        exp_dr = 8'h00;
        frames.delete();
        tick(20);
        check("no_spontaneous_start", 64'(frames.size()), 64'd0);
        run_seq(1, 0, 8'hC3, 0);

        // en held high through reset release
        srst_n = 1'b0;
        en     = 1'b1;
        tick(2);
        srst_n = 1'b1;
        frames.delete();
        setup_model(0, 0, 8'($urandom));
        @(posedge sclk);
        #1;
        check("start_after_rst", 64'(spi_cs), 64'd0);
        tick(2);
        en = 1'b0;
        finish_seq();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

endmodule

// File: doc/flash.md
FLASH -- requirements
Module: flash

Interface
REQ-001 Parameter ADDR, default 24'h000000: flash byte address used for program and read.
REQ-002 Parameter WR_DATA, default 8'hA5: byte programmed to ADDR.
REQ-003 Parameter CLK_DIV, default 2: spi_clk half-period in sclk cycles; legal range 1-255.
REQ-004 Parameter CS_GAP, default 4: minimum sclk cycles spi_cs stays high between commands.
REQ-005 Parameter POLL_MAX, default 65535: maximum status reads per busy wait.
REQ-006 sclk  input  1  system clock; all logic on its rising edge.
REQ-007 srst_n  input  1  reset, synchronous, active-low.
REQ-008 en  input  1  start request; a 0->1 transition starts one sequence.
REQ-009 spi_di  input  1  serial data from flash (MISO).
REQ-010 spi_clk  output  1  SPI clock, mode 0, idles low.
REQ-011 spi_do  output  1  serial data to flash (MOSI), MSB first.
REQ-012 spi_cs  output  1  chip select, active-low.
REQ-013 datareadout  output  8  byte read back from ADDR.

Function
REQ-014 en SHALL be registered; start = en & ~en_q; start SHALL be ignored unless state is IDLE.
REQ-015 Sequence SHALL be: IDLE -> WREN(0x06) -> PROG(0x02, ADDR[23:0], WR_DATA) -> POLL -> READ(0x03, ADDR[23:0], 1 byte in) -> IDLE.
REQ-016 Each command SHALL be one spi_cs-low frame; spi_cs SHALL fall CLK_DIV sclk cycles before the first spi_clk rise and rise CLK_DIV cycles after the last spi_clk fall.
REQ-017 Between frames spi_cs SHALL remain high for at least CS_GAP sclk cycles.
REQ-018 spi_do SHALL change only while spi_clk is low (on the falling edge or at frame start); spi_di SHALL be sampled in the sclk cycle in which spi_clk rises.
REQ-019 Each spi_clk high and low phase SHALL last exactly CLK_DIV sclk cycles; frame bit counts: WREN 8, PROG 40, status 16, READ 40.
REQ-020 POLL SHALL issue status read 0x05 frames (8 out, 8 in); bit0 (WIP) = 0 -> next state; WIP = 1 -> CS_GAP then repeat.
REQ-021 After POLL_MAX reads with WIP still 1, the block SHALL abort to IDLE without the READ frame; datareadout unchanged.
REQ-022 In READ, datareadout SHALL update once, one sclk cycle after the 8th data bit is sampled, MSB first; it SHALL hold until the next successful read or reset.
REQ-023 spi_do SHALL be 0 whenever spi_cs is high and during input-only bits.
REQ-024 In IDLE: spi_cs = 1, spi_clk = 0, spi_do = 0.
REQ-025 An en edge during a sequence SHALL be discarded, not queued.

Reset
REQ-026 srst_n low at a sclk edge SHALL set state IDLE, spi_cs 1, spi_clk 0, spi_do 0, datareadout 8'h00, en_q 0, all counters 0.
REQ-027 Reset mid-frame SHALL abort immediately; spi_cs SHALL be high on the cycle after the reset edge; no partial datareadout update.
REQ-028 en held high during reset release SHALL start a sequence on the first clock after release (en_q reset value 0).

Configuration
REQ-029 Macro FLASH_ERASE_EN defined: before PROG the block SHALL issue WREN(0x06), SECTOR_ERASE(0x20, ADDR[23:12],12'h000; 32 bits), then POLL under the same rules as REQ-020/021; timeout aborts before PROG.
REQ-030 FLASH_ERASE_EN undefined: no erase frames; sequence exactly per REQ-015.

Verification
REQ-031 Reset, en 0->1, flash model with WIP cleared after 3 polls and byte 0xA5 stored -> frames 0x06, 0x02 000000 A5, 0x05 x3, 0x03 000000; datareadout = 8'hA5.
REQ-032 spi_di tied 1, POLL_MAX = 4 -> exactly 4 status frames, then IDLE, no 0x03 frame, datareadout = 8'h00.
REQ-033 CLK_DIV = 2 -> spi_clk high/low phases each 2 sclk cycles; spi_cs high gap >= CS_GAP = 4 cycles between frames.
REQ-034 srst_n asserted during PROG bit 20 -> spi_cs = 1, spi_clk = 0 next cycle; next en edge restarts at WREN.
REQ-035 Second en edge during POLL -> ignored; exactly one sequence completes.
REQ-036 FLASH_ERASE_EN defined, ADDR = 24'h012345 -> erase frame 0x20 012000 precedes program frame 0x02 012345 A5.
